// File: rtl/rr_request_arbiter.sv
// Round-robin request arbiter with hold limit, feeding an 8-to-3 encoder.
// Grants are registered one-hot, held until release, withdraw or timeout.
module rr_request_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         owner_release,  // "release" is a reserved word
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N - 1);
  localparam logic [N-1:0]     ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_r;
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] owner_r;
  logic [CNT_W-1:0] cnt_r;
  logic [N-1:0]     grant_r;
  logic             busy_r;
  logic             timeout_r;

  logic [PTR_W-1:0] winner_s;
  logic             any_req_s;
  logic             withdraw_s;
  logic             hold_last_s;
  logic             revoke_s;
  logic [PTR_W-1:0] ptr_next_s;

  // First set request at or after p, wrapping modulo N.
  function automatic logic [PTR_W-1:0] pick_winner(input logic [N-1:0] r,
                                                   input logic [PTR_W-1:0] p);
    logic             found;
    logic [PTR_W-1:0] w;
    int               idx;
    found = 1'b0;
    w     = p;
    for (int i = 0; i < N; i++) begin
      idx = (int'(p) + i) % N;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = PTR_W'(idx);
      end else begin
        found = found;
      end
    end
    return w;
  endfunction

  // Winner selection and grant end conditions.
  always_comb begin
    winner_s    = pick_winner(req, ptr_r);
    any_req_s   = |req;
    withdraw_s  = ~req[owner_r];
    hold_last_s = (MAX_HOLD != 0) && (cnt_r == HOLD_LAST);
    revoke_s    = owner_release | withdraw_s | hold_last_s;
    if (owner_r == PTR_LAST) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = owner_r + PTR_W'(1);
    end
  end

  // Arbitration FSM with registered grant/busy/timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      owner_r   <= '0;
      cnt_r     <= '0;
      grant_r   <= '0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout_r <= 1'b0;
          if (any_req_s) begin
            grant_r <= ONE_HOT0 << winner_s;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
            owner_r <= winner_s;
            state_r <= GRANT;
          end
        end
        GRANT: begin
          if (revoke_s) begin
            grant_r   <= '0;
            busy_r    <= 1'b0;
            ptr_r     <= ptr_next_s;
            // Only a pure hold-limit revoke is reported as a timeout.
            timeout_r <= hold_last_s & ~owner_release & ~withdraw_s;
            state_r   <= IDLE;
          end else begin
            cnt_r     <= cnt_r + CNT_W'(1);
            timeout_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          grant_r   <= '0;
          busy_r    <= 1'b0;
          timeout_r <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = grant_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Directed, table-driven bench for rr_request_arbiter (N=8, MAX_HOLD=16),
// plus hand-written timeout and mid-grant reset sequences.
module tb_rr_request_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;
  } vec_t;

  vec_t tbl[$];

  rr_request_arbiter #(.N(8), .MAX_HOLD(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .owner_release (rel),
    .grant         (grant),
    .busy          (busy),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [7:0] q, input logic l,
                              input logic [7:0] g, input logic b, input logic t);
    vec_t v;
    v.rst_n = r; v.req = q; v.rel = l; v.grant = g; v.busy = b; v.timeout = t;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic [7:0] q, input logic l);
    rst_n = r; req = q; rel = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic b, input logic t);
    chk({tag, " grant"}, grant, g);
    chk({tag, " busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, " timeout"}, {7'd0, timeout}, {7'd0, t});
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; rel = 1'b0;
    #1;

    // reset with all requests pending, then first grant from ptr 0
    add(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    // single request, release, then pointer lands on bit 5
    add(1'b1, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0);
    add(1'b1, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0);
    add(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 8'h20, 1'b1, 1'b0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    // full rotation from ptr 0 with a gap cycle between grants
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      add(1'b1, 8'hFF, 1'b0, 8'(8'h01 << i), 1'b1, 1'b0);
      add(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    add(1'b1, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    // wrap: ptr 5 with req 05 -> bit 0; ptr 1 with req 05 -> bit 2
    add(1'b1, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0);
    add(1'b1, 8'h05, 1'b1, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'h05, 1'b0, 8'h01, 1'b1, 1'b0);
    add(1'b1, 8'h05, 1'b1, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'h05, 1'b0, 8'h04, 1'b1, 1'b0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    // release ignored in IDLE; other req bits ignored during GRANT
    add(1'b1, 8'h08, 1'b1, 8'h08, 1'b1, 1'b0);
    add(1'b1, 8'h0F, 1'b0, 8'h08, 1'b1, 1'b0);
    add(1'b1, 8'hF7, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].rel);
      chk_out($sformatf("row%0d", i), tbl[i].grant, tbl[i].busy, tbl[i].timeout);
    end

    // hold limit: 16 grant cycles, timeout pulse in the idle cycle, re-grant
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    chk_out("hold c1", 8'h01, 1'b1, 1'b0);
    for (int k = 2; k <= 16; k++) begin
      step(1'b1, 8'h01, 1'b0);
      chk_out($sformatf("hold c%0d", k), 8'h01, 1'b1, 1'b0);
    end
    step(1'b1, 8'h01, 1'b0);
    chk_out("hold revoke", 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h01, 1'b0);
    chk_out("hold regrant", 8'h01, 1'b1, 1'b0);
    for (int k = 2; k <= 16; k++) begin
      step(1'b1, 8'h01, 1'b0);
      chk({"hold2 grant ", $sformatf("%0d", k)}, grant, 8'h01);
    end
    step(1'b1, 8'h01, 1'b1);
    chk_out("release at limit", 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    chk_out("after release at limit", 8'h01, 1'b1, 1'b0);

    // asynchronous reset in the middle of a grant
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    chk_out("pre-reset grant", 8'h08, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async reset", 8'h00, 1'b0, 1'b0);
    req = 8'h88;
    @(posedge clk);
    #1;
    chk_out("held in reset", 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b0);
    chk_out("post-reset ptr0", 8'h08, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
